// File: rtl/thresholding_accu_pool_pkg.sv
// Shared types and helpers for the thresholding accumulation pool.
// Phase encoding plus a counter-width helper that stays legal for a count of 1.
package thresholding_accu_pool_pkg;

  typedef enum logic [1:0] {
    PH_FIRST,
    PH_MID,
    PH_LAST,
    PH_ONLY
  } phase_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/thresholding_accu_pool_accu_ram.sv
// Per-fold accumulator storage: asynchronous read, synchronous write (distributed RAM).
// Contents are deliberately not reset; the FIRST pixel always overwrites an entry.
module thresholding_accu_pool_accu_ram #(
  parameter int DEPTH  = 1,
  parameter int DW     = 8,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/thresholding_accu_pool.sv
// Per-channel frame sum over N_PIX pixels of a PE-wide, CF-fold rotating stream.
// One widened output beat per fold is emitted on the LAST pixel of each frame.
module thresholding_accu_pool
  import thresholding_accu_pool_pkg::*;
#(
  parameter int W      = 8,
  parameter int C      = 1,
  parameter int PE     = 1,
  parameter bit SIGNED = 1'b0,
  parameter int N_PIX  = 1,
  localparam int CF    = C / PE,
  localparam int AW    = W + $clog2(N_PIX)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   irdy,
  input  logic                   ivld,
  input  logic [PE-1:0][W-1:0]   idat,
  input  logic                   ordy,
  output logic                   ovld,
  output logic [PE-1:0][AW-1:0]  odat
);

  localparam int CW = cnt_w(CF);
  localparam int PW = cnt_w(N_PIX);
  localparam logic [CW-1:0] CF_LAST  = CW'(CF - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(N_PIX - 1);

  logic [CW-1:0]          cf_cnt_reg, cf_cnt_next;
  logic [PW-1:0]          pix_cnt_reg, pix_cnt_next;
  logic                   ovld_reg;
  logic [PE-1:0][AW-1:0]  odat_reg;
  logic [PE-1:0][AW-1:0]  ext_lane, acc_rd, sum_lane;
  phase_e                 phase;
  logic                   is_first, is_last, in_xfer;

  always_comb begin
    phase = PH_MID;
    if (N_PIX == 1)                  phase = PH_ONLY;
    else if (pix_cnt_reg == '0)      phase = PH_FIRST;
    else if (pix_cnt_reg == PIX_LAST) phase = PH_LAST;
  end

  assign is_first = (phase == PH_FIRST) || (phase == PH_ONLY);
  assign is_last  = (phase == PH_LAST)  || (phase == PH_ONLY);

  // Only LAST beats need the output register, so only they can be stalled.
  assign irdy    = !is_last || !ovld_reg || ordy;
  assign in_xfer = ivld && irdy;

  // Lanes are independent: each is widened and summed on its own.
  for (genvar gi = 0; gi < PE; gi++) begin : g_lane
    if (SIGNED) begin : g_sext
      assign ext_lane[gi] = AW'($signed(idat[gi]));
    end else begin : g_zext
      assign ext_lane[gi] = AW'(idat[gi]);
    end
    assign sum_lane[gi] = (is_first ? '0 : acc_rd[gi]) + ext_lane[gi];
  end

  thresholding_accu_pool_accu_ram #(
    .DEPTH  (CF),
    .DW     (PE * AW),
    .ADDR_W (CW)
  ) u_accu_ram (
    .clk   (clk),
    .we    (in_xfer && !is_last),
    .addr  (cf_cnt_reg),
    .wdata (sum_lane),
    .rdata (acc_rd)
  );

  always_comb begin
    cf_cnt_next  = cf_cnt_reg;
    pix_cnt_next = pix_cnt_reg;
    if (in_xfer) begin
      if (cf_cnt_reg == CF_LAST) begin
        cf_cnt_next  = '0;
        pix_cnt_next = (pix_cnt_reg == PIX_LAST) ? '0 : pix_cnt_reg + 1'b1;
      end else begin
        cf_cnt_next = cf_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cf_cnt_reg  <= '0;
      pix_cnt_reg <= '0;
      ovld_reg    <= 1'b0;
      odat_reg    <= '0;
    end else begin
      cf_cnt_reg  <= cf_cnt_next;
      pix_cnt_reg <= pix_cnt_next;
      // A LAST beat can reload in the same cycle the previous result drains.
      if (in_xfer && is_last) begin
        ovld_reg <= 1'b1;
        odat_reg <= sum_lane;
      end else if (ordy) begin
        ovld_reg <= 1'b0;
      end
    end
  end

  assign ovld = ovld_reg;
  assign odat = odat_reg;

endmodule

// File: tb/tb_thresholding_accu_pool.sv
// Directed and randomized checks of thresholding_accu_pool on three configurations.
// Inputs change 1 time unit after posedge; outputs are sampled on the negedge.
module tb_thresholding_accu_pool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Config A: W=2, C=2, PE=1, unsigned, N_PIX=3 -> AW=4
  logic            a_rst = 1'b1, a_ivld = 1'b0, a_ordy = 1'b1;
  logic            a_irdy, a_ovld;
  logic [0:0][1:0] a_idat = '0;
  logic [0:0][3:0] a_odat;

  // Config B: W=3, C=2, PE=2, signed, N_PIX=4 -> AW=5
  logic            b_rst = 1'b1, b_ivld = 1'b0, b_ordy = 1'b1;
  logic            b_irdy, b_ovld;
  logic [1:0][2:0] b_idat = '0;
  logic [1:0][4:0] b_odat;

  // Config C: W=4, C=4, PE=2, unsigned, N_PIX=1 -> AW=4
  logic            c_rst = 1'b1, c_ivld = 1'b0, c_ordy = 1'b1;
  logic            c_irdy, c_ovld;
  logic [1:0][3:0] c_idat = '0;
  logic [1:0][3:0] c_odat;

  thresholding_accu_pool #(.W(2), .C(2), .PE(1), .SIGNED(1'b0), .N_PIX(3)) u1 (
    .clk(clk), .rst(a_rst), .irdy(a_irdy), .ivld(a_ivld), .idat(a_idat),
    .ordy(a_ordy), .ovld(a_ovld), .odat(a_odat));

  thresholding_accu_pool #(.W(3), .C(2), .PE(2), .SIGNED(1'b1), .N_PIX(4)) u2 (
    .clk(clk), .rst(b_rst), .irdy(b_irdy), .ivld(b_ivld), .idat(b_idat),
    .ordy(b_ordy), .ovld(b_ovld), .odat(b_odat));

  thresholding_accu_pool #(.W(4), .C(4), .PE(2), .SIGNED(1'b0), .N_PIX(1)) u4 (
    .clk(clk), .rst(c_rst), .irdy(c_irdy), .ivld(c_ivld), .idat(c_idat),
    .ordy(c_ordy), .ovld(c_ovld), .odat(c_odat));

  // Collect every config-A output transfer.
  int a_outq[$];
  initial forever begin
    @(negedge clk);
    if (a_ovld && a_ordy) a_outq.push_back(int'(a_odat[0]));
  end

  bit rand_ordy = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ordy) a_ordy = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one beat on config A; waits = stalled cycles, or -1 on timeout.
  task automatic a_send(input logic [1:0] d, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    a_idat[0] = d;
    a_ivld = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = a_irdy;
      if (!done) waits++;
      @(posedge clk);
      #1;
    end
    a_ivld = 1'b0;
    if (!done) waits = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    idle(2);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    total++; if (a_ovld !== 1'b0) $display("FAIL reset_a_ovld: got %b want 0", a_ovld); else passed++;
    total++; if (a_odat !== '0) $display("FAIL reset_a_odat: got %0d want 0", a_odat[0]); else passed++;
    total++; if (a_irdy !== 1'b1) $display("FAIL reset_a_irdy: got %b want 1", a_irdy); else passed++;
    total++; if (u1.cf_cnt_reg !== '0) $display("FAIL reset_cf_cnt: got %0d want 0", u1.cf_cnt_reg); else passed++;
    total++; if (u1.pix_cnt_reg !== '0) $display("FAIL reset_pix_cnt: got %0d want 0", u1.pix_cnt_reg); else passed++;
    total++; if (b_ovld !== 1'b0 || b_odat !== '0) $display("FAIL reset_b: got ovld=%b odat=%h want 0/0", b_ovld, b_odat); else passed++;
    total++; if (c_ovld !== 1'b0 || c_irdy !== 1'b1) $display("FAIL reset_c: got ovld=%b irdy=%b want 0/1", c_ovld, c_irdy); else passed++;
  endtask

  task automatic test_unsigned;
    int vals[6] = '{1, 3, 1, 3, 1, 3};
    int w;
    bit stalled;
    stalled = 1'b0;
    a_outq.delete();
    a_ordy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_send(2'(vals[i]), w);
      if (w != 0) stalled = 1'b1;
      if (i == 4) begin
        total++; if (a_ovld !== 1'b1 || a_odat[0] !== 4'd3) $display("FAIL unsigned_ch0: got ovld=%b odat=%0d want 1/3", a_ovld, a_odat[0]); else passed++;
      end
      if (i == 5) begin
        total++; if (a_ovld !== 1'b1 || a_odat[0] !== 4'd9) $display("FAIL unsigned_ch1: got ovld=%b odat=%0d want 1/9", a_ovld, a_odat[0]); else passed++;
      end
    end
    total++; if (stalled) $display("FAIL unsigned_stall: got stall want none"); else passed++;
    idle(1);
    total++; if (a_ovld !== 1'b0) $display("FAIL unsigned_pulse: got ovld=%b want 0", a_ovld); else passed++;
    idle(1);
    total++;
    if (a_outq.size() != 2 || a_outq[0] != 3 || a_outq[1] != 9)
      $display("FAIL unsigned_stream: got %p want '{3,9}", a_outq);
    else passed++;
  endtask

  task automatic test_signed;
    bit stalled;
    logic [2:0] l0 [4];
    stalled = 1'b0;
    b_ordy = 1'b1;
    b_idat[0] = 3'b100;
    b_idat[1] = 3'b011;
    b_ivld = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!b_irdy) stalled = 1'b1;
      @(posedge clk);
      #1;
    end
    b_ivld = 1'b0;
    total++; if (stalled) $display("FAIL signed_stall: got stall want none"); else passed++;
    total++; if (b_ovld !== 1'b1) $display("FAIL signed_ovld: got %b want 1", b_ovld); else passed++;
    total++; if (b_odat[1] !== 5'b01100) $display("FAIL signed_lane1: got %b want 01100", b_odat[1]); else passed++;
    total++; if (b_odat[0] !== 5'b10000) $display("FAIL signed_lane0: got %b want 10000", b_odat[0]); else passed++;
    // Mixed signs on lane0: 3 + -1 + 0 + 2 = 4; lane1 all -4 -> -16
    l0 = '{3'b011, 3'b111, 3'b000, 3'b010};
    b_idat[1] = 3'b100;
    b_ivld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_idat[0] = l0[i];
      @(posedge clk);
      #1;
    end
    b_ivld = 1'b0;
    total++; if (b_ovld !== 1'b1 || b_odat[0] !== 5'b00100 || b_odat[1] !== 5'b10000)
      $display("FAIL signed_mixed: got ovld=%b lane1=%b lane0=%b want 1/10000/00100", b_ovld, b_odat[1], b_odat[0]); else passed++;
    idle(1);
    total++; if (b_ovld !== 1'b0) $display("FAIL signed_pulse: got %b want 0", b_ovld); else passed++;
  endtask

  task automatic test_pass_through;
    logic [1:0][3:0] sent;
    bit stalled;
    stalled = 1'b0;
    c_ordy = 1'b1;
    c_ivld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c_idat = 8'($urandom);
      sent = c_idat;
      @(negedge clk);
      if (!c_irdy) stalled = 1'b1;
      @(posedge clk);
      #1;
      total++; if (c_ovld !== 1'b1 || c_odat !== sent)
        $display("FAIL pass_beat%0d: got ovld=%b odat=%h want 1/%h", i, c_ovld, c_odat, sent); else passed++;
    end
    c_ivld = 1'b0;
    total++; if (stalled) $display("FAIL pass_stall: got stall want none"); else passed++;
    idle(1);
    total++; if (c_ovld !== 1'b0) $display("FAIL pass_drain: got ovld=%b want 0", c_ovld); else passed++;
  endtask

  task automatic test_backpressure;
    int w;
    bit bad;
    int exp4[4] = '{3, 9, 3, 9};
    a_outq.delete();
    a_ordy = 1'b0;
    a_send(2'd1, w); a_send(2'd3, w); a_send(2'd1, w); a_send(2'd3, w); a_send(2'd1, w);
    total++; if (a_ovld !== 1'b1 || a_odat[0] !== 4'd3) $display("FAIL bp_first_out: got ovld=%b odat=%0d want 1/3", a_ovld, a_odat[0]); else passed++;
    a_idat[0] = 2'd3;
    a_ivld = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (a_irdy !== 1'b0 || a_ovld !== 1'b1 || a_odat[0] !== 4'd3) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    total++; if (bad) $display("FAIL bp_hold: got irdy=%b ovld=%b odat=%0d want 0/1/3", a_irdy, a_ovld, a_odat[0]); else passed++;
    a_ordy = 1'b1;
    @(negedge clk);
    total++; if (a_irdy !== 1'b1) $display("FAIL bp_release_irdy: got %b want 1", a_irdy); else passed++;
    @(posedge clk);
    #1;
    a_ivld = 1'b0;
    a_ordy = 1'b0;
    total++; if (a_ovld !== 1'b1 || a_odat[0] !== 4'd9) $display("FAIL bp_reload: got ovld=%b odat=%0d want 1/9", a_ovld, a_odat[0]); else passed++;
    a_send(2'd1, w);
    total++; if (w !== 0) $display("FAIL bp_first_accept0: got waits=%0d want 0", w); else passed++;
    a_send(2'd3, w);
    total++; if (w !== 0) $display("FAIL bp_first_accept1: got waits=%0d want 0", w); else passed++;
    total++; if (a_ovld !== 1'b1 || a_odat[0] !== 4'd9) $display("FAIL bp_pending: got ovld=%b odat=%0d want 1/9", a_ovld, a_odat[0]); else passed++;
    a_ordy = 1'b1;
    a_send(2'd1, w); a_send(2'd3, w); a_send(2'd1, w); a_send(2'd3, w);
    idle(2);
    bad = (a_outq.size() != 4);
    for (int i = 0; i < 4 && !bad; i++) if (a_outq[i] != exp4[i]) bad = 1'b1;
    total++; if (bad) $display("FAIL bp_stream: got %p want '{3,9,3,9}", a_outq); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    int w;
    a_outq.delete();
    a_ordy = 1'b1;
    repeat (4) a_send(2'd3, w);
    a_rst = 1'b1;
    idle(1);
    a_rst = 1'b0;
    total++; if (a_ovld !== 1'b0) $display("FAIL rst_mid_ovld: got %b want 0", a_ovld); else passed++;
    total++; if (u1.cf_cnt_reg !== '0 || u1.pix_cnt_reg !== '0)
      $display("FAIL rst_mid_cnt: got cf=%0d pix=%0d want 0/0", u1.cf_cnt_reg, u1.pix_cnt_reg); else passed++;
    total++; if (a_irdy !== 1'b1) $display("FAIL rst_mid_irdy: got %b want 1", a_irdy); else passed++;
    repeat (6) a_send(2'd2, w);
    idle(2);
    total++;
    if (a_outq.size() != 2 || a_outq[0] != 6 || a_outq[1] != 6)
      $display("FAIL rst_mid_stream: got %p want '{6,6}", a_outq);
    else passed++;
  endtask

  task automatic test_random;
    int expq[$];
    int s0, s1, d, w, timeouts;
    timeouts = 0;
    a_outq.delete();
    rand_ordy = 1'b1;
    for (int f = 0; f < 100; f++) begin
      s0 = 0;
      s1 = 0;
      for (int p = 0; p < 3; p++) begin
        for (int ch = 0; ch < 2; ch++) begin
          d = $urandom_range(0, 3);
          if (ch == 0) s0 += d; else s1 += d;
          if ($urandom_range(0, 3) == 0) idle(1);
          a_send(2'(d), w);
          if (w < 0) timeouts++;
        end
      end
      expq.push_back(s0);
      expq.push_back(s1);
    end
    rand_ordy = 1'b0;
    @(posedge clk);
    #2;
    a_ordy = 1'b1;
    idle(4);
    total++; if (timeouts != 0) $display("FAIL rand_timeout: got %0d timeouts want 0", timeouts); else passed++;
    total++; if (a_outq.size() != expq.size()) $display("FAIL rand_count: got %0d outputs want %0d", a_outq.size(), expq.size()); else passed++;
    for (int i = 0; i < expq.size(); i++) begin
      if (i < a_outq.size()) begin
        total++; if (a_outq[i] != expq[i]) $display("FAIL rand_out%0d: got %0d want %0d", i, a_outq[i], expq[i]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_pass_through();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
